// File: rtl/fpu_double.sv
// fpu_double: IEEE-754 binary64 add / sub / mul / div unit, one operation in
// flight, enable/ready handshake. Subnormals are treated as zero on input and
// flushed to zero on output.
// Build option: define FPU_DIV_EN to include the radix-2 restoring divider;
// without it, fpu_op 011 behaves as a reserved opcode.
module fpu_double (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] out,
  output logic        ready,
  output logic        underflow,
  output logic        overflow,
  output logic        inexact,
  output logic        exception,
  output logic        invalid
);
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [5:0] cnt, lat;
  logic [63:0] opa_p0, opb_p0;
  logic [2:0] op_p0;
  logic [1:0] rmode_p0;

  // Round a normalised significand on guard/round/sticky and pack it.
  // Returns {result[63:0], overflow, underflow, inexact}.
  function automatic logic [66:0] round_pack(input logic sign, input logic signed [12:0] ein,
      input logic [52:0] mant, input logic g, input logic r, input logic s, input logic [1:0] rm);
    logic inc, lost;
    logic [53:0] sum;
    logic signed [12:0] e;
    logic [51:0] frac;
    lost = g | r | s;
    case (rm)
      2'b00:   inc = g & (r | s | mant[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = ~sign & lost;
      default: inc = sign & lost;
    endcase
    sum = {1'b0, mant} + {53'd0, inc};
    e = ein;
    frac = sum[51:0];
    if (sum[53]) begin
      e = ein + 13'sd1;
      frac = sum[52:1];
    end
    if (e >= 13'sd2047) begin
      if (rm == 2'b00 || (rm == 2'b10 && !sign) || (rm == 2'b11 && sign))
        round_pack = {sign, 11'h7FF, 52'd0, 3'b101};
      else
        round_pack = {sign, 11'h7FE, {52{1'b1}}, 3'b101};
    end else if (e <= 13'sd0) begin
      round_pack = {sign, 63'd0, 3'b011};
    end else begin
      round_pack = {sign, e[10:0], frac, 2'b00, lost};
    end
  endfunction

  // Leading-zero count of a 56-bit vector (56 when all zero).
  function automatic logic [5:0] lzc56(input logic [55:0] v);
    lzc56 = 6'd56;
    for (int i = 0; i < 56; i++)
      if (v[i]) lzc56 = 6'(55 - i);
  endfunction

  // ---- p0: captured operands, unpacked ----
  logic        sa, sb, sbe, za, zb, ia, ib, na, nb, snan;
  logic [10:0] ea, eb;
  logic [51:0] fa_m, fb_m;
  logic [52:0] ma, mb;
  assign sa   = opa_p0[63];
  assign sb   = opb_p0[63];
  assign sbe  = sb ^ (op_p0 == 3'b001);
  assign ea   = opa_p0[62:52];
  assign eb   = opb_p0[62:52];
  assign za   = (ea == 11'd0);
  assign zb   = (eb == 11'd0);
  assign ia   = (ea == 11'h7FF) && (opa_p0[51:0] == 52'd0);
  assign ib   = (eb == 11'h7FF) && (opb_p0[51:0] == 52'd0);
  assign na   = (ea == 11'h7FF) && (opa_p0[51:0] != 52'd0);
  assign nb   = (eb == 11'h7FF) && (opb_p0[51:0] != 52'd0);
  assign snan = (na && !opa_p0[51]) || (nb && !opb_p0[51]);
  assign fa_m = za ? 52'd0 : opa_p0[51:0];
  assign fb_m = zb ? 52'd0 : opb_p0[51:0];
  assign ma   = {~za, fa_m};
  assign mb   = {~zb, fb_m};

  // ---- add/sub path: align, add, normalise, round ----
  logic               a_big, add_sign, add_sub;
  logic [10:0]        el, es, ediff;
  logic [52:0]        ml, msm;
  logic [111:0]       shv;
  logic [55:0]        al, anorm;
  logic [56:0]        asum;
  logic [5:0]         alz;
  logic signed [12:0] aexp;
  logic [66:0]        add_res;

  // Magnitude add/subtract with sticky-preserving alignment shift.
  always_comb begin
    a_big    = {ea, fa_m} >= {eb, fb_m};
    el       = a_big ? ea : eb;
    es       = a_big ? eb : ea;
    ml       = a_big ? ma : mb;
    msm      = a_big ? mb : ma;
    add_sign = a_big ? sa : sbe;
    add_sub  = sa ^ sbe;
    ediff    = el - es;
    shv      = {msm, 59'd0} >> ediff;
    al       = shv[111:56] | {55'd0, |shv[55:0]};
    if (ediff >= 11'd56) al = {55'd0, |msm};
    asum  = add_sub ? ({1'b0, ml, 3'b000} - {1'b0, al}) : ({1'b0, ml, 3'b000} + {1'b0, al});
    alz   = lzc56(asum[55:0]);
    anorm = asum[55:0] << alz;
    aexp  = $signed({2'b00, el}) - $signed({7'd0, alz});
    if (asum[56]) begin
      anorm = {asum[56:2], asum[1] | asum[0]};
      aexp  = $signed({2'b00, el}) + 13'sd1;
    end
    add_res = round_pack(add_sign, aexp, anorm[55:3], anorm[2], anorm[1], anorm[0], rmode_p0);
    if (asum == 57'd0)
      add_res = {(za && zb && sa == sbe) ? sa : (rmode_p0 == 2'b11), 63'd0, 3'b000};
  end

  // ---- mul path ----
  logic [105:0]       prod;
  logic signed [12:0] mexp;
  logic [66:0]        mul_res;

  // 53x53 product, one-bit normalisation, round.
  always_comb begin
    prod = ma * mb;
    mexp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 13'sd1023;
    if (prod[105])
      mul_res = round_pack(sa ^ sb, mexp + 13'sd1, prod[105:53], prod[52], prod[51], |prod[50:0], rmode_p0);
    else
      mul_res = round_pack(sa ^ sb, mexp, prod[104:52], prod[51], prod[50], |prod[49:0], rmode_p0);
  end

`ifdef FPU_DIV_EN
  // ---- p1: iterative divider state ----
  logic [54:0]        rem_p1;
  logic [55:0]        quo_p1;
  logic signed [12:0] dexp;
  logic [66:0]        div_res;

  // Restoring division: load at the first busy cycle, then one quotient bit per cycle.
  always_ff @(posedge clk_operation) begin
    if (state == BUSY && op_p0 == 3'b011) begin
      if (cnt == 6'd57) begin
        rem_p1 <= {2'b00, ma};
        quo_p1 <= '0;
      end else if (cnt != 6'd0) begin
        if (rem_p1 >= {2'b00, mb}) begin
          rem_p1 <= (rem_p1 - {2'b00, mb}) << 1;
          quo_p1 <= {quo_p1[54:0], 1'b1};
        end else begin
          rem_p1 <= rem_p1 << 1;
          quo_p1 <= {quo_p1[54:0], 1'b0};
        end
      end
    end
  end

  // Quotient normalisation and rounding; remainder feeds the sticky bit.
  always_comb begin
    dexp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023;
    if (quo_p1[55])
      div_res = round_pack(sa ^ sb, dexp, quo_p1[55:3], quo_p1[2], quo_p1[1], quo_p1[0] | (|rem_p1), rmode_p0);
    else
      div_res = round_pack(sa ^ sb, dexp - 13'sd1, quo_p1[54:2], quo_p1[1], quo_p1[0], |rem_p1, rmode_p0);
  end
`endif

  // ---- result select: special operands override the arithmetic paths ----
  logic [66:0] res;
  logic        res_inv, res_dz;

  // Pick the arithmetic result or the special-case value for the latched opcode.
  always_comb begin
    res     = add_res;
    res_inv = 1'b0;
    res_dz  = 1'b0;
    case (op_p0)
      3'b000, 3'b001: begin
        if (na || nb) begin res = {QNAN, 3'b000}; res_inv = snan; end
        else if (ia && ib && sa != sbe) begin res = {QNAN, 3'b000}; res_inv = 1'b1; end
        else if (ia) res = {sa, 11'h7FF, 52'd0, 3'b000};
        else if (ib) res = {sbe, 11'h7FF, 52'd0, 3'b000};
        else res = add_res;
      end
      3'b010: begin
        if (na || nb) begin res = {QNAN, 3'b000}; res_inv = snan; end
        else if ((ia && zb) || (za && ib)) begin res = {QNAN, 3'b000}; res_inv = 1'b1; end
        else if (ia || ib) res = {sa ^ sb, 11'h7FF, 52'd0, 3'b000};
        else if (za || zb) res = {sa ^ sb, 63'd0, 3'b000};
        else res = mul_res;
      end
`ifdef FPU_DIV_EN
      3'b011: begin
        if (na || nb) begin res = {QNAN, 3'b000}; res_inv = snan; end
        else if ((za && zb) || (ia && ib)) begin res = {QNAN, 3'b000}; res_inv = 1'b1; end
        else if (ia) res = {sa ^ sb, 11'h7FF, 52'd0, 3'b000};
        else if (ib || za) res = {sa ^ sb, 63'd0, 3'b000};
        else if (zb) begin res = {sa ^ sb, 11'h7FF, 52'd0, 3'b000}; res_dz = 1'b1; end
        else res = div_res;
      end
`endif
      default: begin res = {QNAN, 3'b000}; res_inv = 1'b1; end
    endcase
  end

  // Busy-cycle count loaded at accept: latency minus one.
  always_comb begin
    lat = 6'd1;
    case (fpu_op)
      3'b000, 3'b001, 3'b010: lat = 6'd3;
`ifdef FPU_DIV_EN
      3'b011: lat = 6'd57;
`endif
      default: lat = 6'd1;
    endcase
  end

  // Operand capture on accepted enable.
  always_ff @(posedge clk_operation) begin
    if ((state == IDLE || state == DONE) && enable) begin
      opa_p0   <= opa;
      opb_p0   <= opb;
      op_p0    <= fpu_op;
      rmode_p0 <= rmode;
    end
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      ready     <= 1'b0;
      out       <= 64'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
      exception <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (enable) begin
            state     <= BUSY;
            cnt       <= lat;
            ready     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            invalid   <= 1'b0;
            exception <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == 6'd0) begin
            state     <= DONE;
            ready     <= 1'b1;
            out       <= res[66:3];
            overflow  <= res[2];
            underflow <= res[1];
            inexact   <= res[0];
            invalid   <= res_inv;
            exception <= res_inv | res[2] | res[1] | res_dz;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_double.sv
// Directed-vector bench for fpu_double; expected values computed by hand.
module tb_fpu_double;
  logic        clk_operation = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  rmode = 2'b00;
  logic [2:0]  fpu_op = 3'b000;
  logic [63:0] opa = 64'd0, opb = 64'd0;
  logic [63:0] out;
  logic        ready, underflow, overflow, inexact, exception, invalid;
  logic [4:0]  flags;
  int checks = 0;
  int errors = 0;
  int lat = 0;

  assign flags = {overflow, underflow, inexact, exception, invalid};

  fpu_double dut (
    .clk_operation(clk_operation), .rst(rst), .enable(enable), .rmode(rmode),
    .fpu_op(fpu_op), .opa(opa), .opb(opb), .out(out), .ready(ready),
    .underflow(underflow), .overflow(overflow), .inexact(inexact),
    .exception(exception), .invalid(invalid)
  );

  always #5 clk_operation = ~clk_operation;

  // Issue one operation and wait (bounded) for ready; lat = rising edges from accept to ready.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm);
    @(negedge clk_operation);
    fpu_op = op; opa = a; opb = b; rmode = rm; enable = 1'b1;
    @(negedge clk_operation);
    enable = 1'b0; opa = '1; opb = '1; fpu_op = 3'b000;
    lat = 0;
    while (ready !== 1'b1 && lat < 100) begin
      @(negedge clk_operation);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_operation);
    checks++; if (out !== 64'd0) begin errors++; $display("FAIL reset_out: got %h expected %h", out, 64'd0); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b expected 00000", flags); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(3'b000, 64'h3FF0000000000000, 64'h4000000000000000, 2'b00);
    checks++; if (out !== 64'h4008000000000000) begin errors++; $display("FAIL add_1p2: got %h expected 4008000000000000", out); end
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL add_1p2_flags: got %b expected 00000", flags); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
    run_op(3'b000, 64'h3FF0000000000000, 64'h3C30000000000000, 2'b00);
    checks++; if (out !== 64'h3FF0000000000000) begin errors++; $display("FAIL add_sticky_rne: got %h expected 3FF0000000000000", out); end
    checks++; if (flags !== 5'b00100) begin errors++; $display("FAIL add_sticky_flags: got %b expected 00100", flags); end
    run_op(3'b000, 64'h3FF0000000000000, 64'h3C30000000000000, 2'b10);
    checks++; if (out !== 64'h3FF0000000000001) begin errors++; $display("FAIL add_sticky_up: got %h expected 3FF0000000000001", out); end
  endtask

  task automatic test_sub();
    run_op(3'b001, 64'h3FF0000000000000, 64'h4008000000000000, 2'b00);
    checks++; if (out !== 64'hC000000000000000) begin errors++; $display("FAIL sub_1m3: got %h expected C000000000000000", out); end
    run_op(3'b001, 64'h3FF0000000000000, 64'h3FF0000000000000, 2'b00);
    checks++; if (out !== 64'h0000000000000000) begin errors++; $display("FAIL sub_zero_rne: got %h expected 0000000000000000", out); end
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL sub_zero_flags: got %b expected 00000", flags); end
    run_op(3'b001, 64'h3FF0000000000000, 64'h3FF0000000000000, 2'b11);
    checks++; if (out !== 64'h8000000000000000) begin errors++; $display("FAIL sub_zero_rdn: got %h expected 8000000000000000", out); end
  endtask

  task automatic test_mul();
    run_op(3'b010, 64'h4008000000000000, 64'h4000000000000000, 2'b00);
    checks++; if (out !== 64'h4018000000000000) begin errors++; $display("FAIL mul_3x2: got %h expected 4018000000000000", out); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL mul_latency: got %0d expected 4", lat); end
    run_op(3'b010, 64'h0000000000000000, 64'h7FF0000000000000, 2'b00);
    checks++; if (out !== 64'h7FF8000000000000) begin errors++; $display("FAIL mul_0xinf: got %h expected 7FF8000000000000", out); end
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL mul_0xinf_flags: got %b expected 00011", flags); end
    run_op(3'b010, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 2'b00);
    checks++; if (out !== 64'h7FF0000000000000) begin errors++; $display("FAIL mul_ovf_rne: got %h expected 7FF0000000000000", out); end
    checks++; if (flags !== 5'b10110) begin errors++; $display("FAIL mul_ovf_flags: got %b expected 10110", flags); end
    run_op(3'b010, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 2'b01);
    checks++; if (out !== 64'h7FEFFFFFFFFFFFFF) begin errors++; $display("FAIL mul_ovf_rtz: got %h expected 7FEFFFFFFFFFFFFF", out); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mul_ovf_rtz_flag: got %b expected 1", overflow); end
    run_op(3'b010, 64'h0010000000000000, 64'h3FE0000000000000, 2'b00);
    checks++; if (out !== 64'h0000000000000000) begin errors++; $display("FAIL mul_unf: got %h expected 0000000000000000", out); end
    checks++; if (flags !== 5'b01110) begin errors++; $display("FAIL mul_unf_flags: got %b expected 01110", flags); end
  endtask

  task automatic test_specials();
    run_op(3'b000, 64'h7FF0000000000001, 64'h3FF0000000000000, 2'b00);
    checks++; if (out !== 64'h7FF8000000000000) begin errors++; $display("FAIL snan_out: got %h expected 7FF8000000000000", out); end
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL snan_flags: got %b expected 00011", flags); end
    run_op(3'b000, 64'h7FF8000000000000, 64'h3FF0000000000000, 2'b00);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL qnan_flags: got %b expected 00000", flags); end
    run_op(3'b001, 64'h7FF0000000000000, 64'h7FF0000000000000, 2'b00);
    checks++; if (out !== 64'h7FF8000000000000) begin errors++; $display("FAIL inf_m_inf: got %h expected 7FF8000000000000", out); end
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL inf_m_inf_flags: got %b expected 00011", flags); end
    run_op(3'b111, 64'h3FF0000000000000, 64'h3FF0000000000000, 2'b00);
    checks++; if (out !== 64'h7FF8000000000000) begin errors++; $display("FAIL reserved_out: got %h expected 7FF8000000000000", out); end
    checks++; if (invalid !== 1'b1) begin errors++; $display("FAIL reserved_invalid: got %b expected 1", invalid); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL reserved_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_div();
`ifdef FPU_DIV_EN
    run_op(3'b011, 64'h3FF0000000000000, 64'h4000000000000000, 2'b00);
    checks++; if (out !== 64'h3FE0000000000000) begin errors++; $display("FAIL div_1d2: got %h expected 3FE0000000000000", out); end
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL div_1d2_flags: got %b expected 00000", flags); end
    checks++; if (lat !== 58) begin errors++; $display("FAIL div_latency: got %0d expected 58", lat); end
    run_op(3'b011, 64'h3FF0000000000000, 64'h0000000000000000, 2'b00);
    checks++; if (out !== 64'h7FF0000000000000) begin errors++; $display("FAIL div_by_zero: got %h expected 7FF0000000000000", out); end
    checks++; if (flags !== 5'b00010) begin errors++; $display("FAIL div_by_zero_flags: got %b expected 00010", flags); end
`else
    run_op(3'b011, 64'h3FF0000000000000, 64'h4000000000000000, 2'b00);
    checks++; if (out !== 64'h7FF8000000000000) begin errors++; $display("FAIL div_reserved: got %h expected 7FF8000000000000", out); end
    checks++; if (flags !== 5'b00011) begin errors++; $display("FAIL div_reserved_flags: got %b expected 00011", flags); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL div_reserved_latency: got %0d expected 2", lat); end
`endif
  endtask

  task automatic test_reset_busy();
    @(negedge clk_operation);
    fpu_op = 3'b010; opa = 64'h4008000000000000; opb = 64'h4000000000000000; rmode = 2'b00; enable = 1'b1;
    @(negedge clk_operation);
    enable = 1'b0;
    @(negedge clk_operation);
    rst = 1'b1;
    @(negedge clk_operation);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_busy_ready: got %b expected 0", ready); end
    checks++; if (out !== 64'd0) begin errors++; $display("FAIL rst_busy_out: got %h expected 0", out); end
    rst = 1'b0;
    repeat (6) @(negedge clk_operation);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_abort_ready: got %b expected 0", ready); end
    run_op(3'b000, 64'h3FF0000000000000, 64'h4000000000000000, 2'b00);
    checks++; if (out !== 64'h4008000000000000) begin errors++; $display("FAIL post_rst_add: got %h expected 4008000000000000", out); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_operation);
    fpu_op = 3'b010; opa = 64'h4008000000000000; opb = 64'h4000000000000000; rmode = 2'b00; enable = 1'b1;
    @(negedge clk_operation);
    fpu_op = 3'b000; opa = 64'h3FF0000000000000; opb = 64'h4000000000000000;
    lat = 0;
    @(negedge clk_operation);
    lat++;
    enable = 1'b0;
    while (ready !== 1'b1 && lat < 100) begin
      @(negedge clk_operation);
      lat++;
    end
    checks++; if (out !== 64'h4018000000000000) begin errors++; $display("FAIL busy_enable_out: got %h expected 4018000000000000", out); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL busy_enable_latency: got %0d expected 4", lat); end
    repeat (3) @(negedge clk_operation);
    checks++; if (out !== 64'h4018000000000000 || ready !== 1'b1) begin errors++; $display("FAIL done_hold: got %h ready %b expected 4018000000000000 ready 1", out, ready); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_specials();
    test_div();
    test_reset_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
